// File: rtl/byte_unstriping_pkg.sv
// Shared types for the two-lane byte un-striping scheduler.
package byte_unstriping_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_L0 = 2'd1,
    ST_RD_L1 = 2'd2
  } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane receive FIFO with a combinational head read and a drop pulse on overflow.
module lane_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the same edge frees a slot.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/byte_unstriping_sched.sv
// Rebuilds the serial word stream from two striped lanes, lane 0 first, with
// skew buffering, stall timeout resync and sticky overflow/timeout flags.
module byte_unstriping_sched
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_MAX = 8,
  parameter int unsigned DW        = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_0,
  input  logic [DW-1:0] lane_0,
  input  logic          valid_1,
  input  logic [DW-1:0] lane_1,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          active,
  output logic          err_overflow,
  output logic          err_timeout
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STALL_MAX) + 1;

  state_t        state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [DW-1:0] data_d;
  logic          valid_d;
  logic          timeout_d;
  logic          pop0, pop1;
  logic          flush;
  logic          fifo_clr;

  logic [DW-1:0] head0, head1;
  logic [CW-1:0] count0, count1;
  logic          full0, full1;
  logic          empty0, empty1;
  logic          ovf0, ovf1;
  logic          full_flags_unused;

  // A timeout flush clears both lanes with the same path as reset.
  assign fifo_clr          = reset | flush;
  assign full_flags_unused = full0 ^ full1;

  lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (fifo_clr),
    .push  (valid_0),
    .din   (lane_0),
    .pop   (pop0),
    .dout  (head0),
    .count (count0),
    .full  (full0),
    .empty (empty0),
    .ovf   (ovf0)
  );

  lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (fifo_clr),
    .push  (valid_1),
    .din   (lane_1),
    .pop   (pop1),
    .dout  (head1),
    .count (count1),
    .full  (full1),
    .empty (empty1),
    .ovf   (ovf1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stall_q      <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      active       <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      data_out     <= data_d;
      valid_out    <= valid_d;
      active       <= (state_d != ST_IDLE);
      err_overflow <= err_overflow | ovf0 | ovf1;
      err_timeout  <= err_timeout | timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    data_d    = data_out;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    flush     = 1'b0;

    case (state_q)
      // Start a stream only once both lanes hold at least one word.
      ST_IDLE: begin
        stall_d = '0;
        if (count0 != '0 && count1 != '0) begin
          pop0    = 1'b1;
          data_d  = head0;
          valid_d = 1'b1;
          state_d = ST_RD_L1;
        end
      end
      ST_RD_L0: begin
        if (!empty0) begin
          pop0    = 1'b1;
          data_d  = head0;
          valid_d = 1'b1;
          stall_d = '0;
          state_d = ST_RD_L1;
        end else if (stall_q == SW'(STALL_MAX - 1)) begin
          flush     = 1'b1;
          timeout_d = 1'b1;
          stall_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      ST_RD_L1: begin
        if (!empty1) begin
          pop1    = 1'b1;
          data_d  = head1;
          valid_d = 1'b1;
          stall_d = '0;
          state_d = ST_RD_L0;
        end else if (stall_q == SW'(STALL_MAX - 1)) begin
          flush     = 1'b1;
          timeout_d = 1'b1;
          stall_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: begin
        stall_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_unstriping_sched.sv
// Directed scoreboard bench for byte_unstriping_sched.
module tb_byte_unstriping_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [31:0] lane_0, lane_1;
  logic [31:0] data_out;
  logic        valid_out, active, err_overflow, err_timeout;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb [$];

  byte_unstriping_sched #(.DEPTH(4), .STALL_MAX(8), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_0      (valid_0),
    .lane_0       (lane_0),
    .valid_1      (valid_1),
    .lane_1       (lane_1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .active       (active),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock edge; any valid_out is matched against the scoreboard head.
  task automatic tick();
    logic [31:0] exp_word;
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 32'(valid_out), 32'd0);
      end else begin
        exp_word = sb.pop_front();
        check("data_out", data_out, exp_word);
      end
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    valid_0 = v0; lane_0 = d0;
    valid_1 = v1; lane_1 = d1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0);

    // Reset then idle
    tick(); tick();
    check("rst_data_out", data_out, 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_valid_out", 32'(valid_out), 32'd0);
    check("idle_active", 32'(active), 32'd0);

    // Aligned pair, then an 8-cycle stall on lane 0 forces a timeout
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h8888_8888);
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h8888_8888);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    check("align_e1_valid", 32'(valid_out), 32'd0);
    tick();
    check("align_e2_valid", 32'(valid_out), 32'd1);
    tick();
    check("align_e3_valid", 32'(valid_out), 32'd1);
    tick();
    check("align_e4_valid", 32'(valid_out), 32'd0);
    check("align_e4_active", 32'(active), 32'd1);
    check("align_e4_hold", data_out, 32'h8888_8888);
    check("align_drain", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("align_pre_timeout", 32'(err_timeout), 32'd0);
    tick();
    check("align_timeout", 32'(err_timeout), 32'd1);
    check("align_timeout_active", 32'(active), 32'd0);

    // Skew: lane 1 arrives three edges after lane 0
    do_reset();
    check("skew_rst_timeout", 32'(err_timeout), 32'd0);
    sb.push_back(32'h7777_7777);
    sb.push_back(32'h5555_5555);
    sb.push_back(32'h9999_9999);
    drive(1'b1, 32'h7777_7777, 1'b0, '0); tick();
    drive(1'b1, 32'h9999_9999, 1'b0, '0); tick();
    check("skew_e2_valid", 32'(valid_out), 32'd0);
    drive(1'b0, '0, 1'b0, '0); tick();
    check("skew_e3_valid", 32'(valid_out), 32'd0);
    drive(1'b0, '0, 1'b1, 32'h5555_5555); tick();
    drive(1'b0, '0, 1'b0, '0);
    check("skew_e4_valid", 32'(valid_out), 32'd0);
    check("skew_e4_active", 32'(active), 32'd0);
    tick(); tick(); tick();
    check("skew_drain", 32'(sb.size()), 32'd0);
    check("skew_err_overflow", 32'(err_overflow), 32'd0);
    check("skew_err_timeout", 32'(err_timeout), 32'd0);

    // Stall timeout on lane 1 after a lane-0-only word
    do_reset();
    sb.push_back(32'hCCCC_CCCC);
    sb.push_back(32'h4444_4444);
    sb.push_back(32'h3333_3333);
    drive(1'b1, 32'hCCCC_CCCC, 1'b1, 32'h4444_4444); tick();
    drive(1'b1, 32'h3333_3333, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b0, '0);
    tick(); tick();
    check("stall_33_out", 32'(valid_out), 32'd1);
    check("stall_drain", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("stall_pre_timeout", 32'(err_timeout), 32'd0);
    check("stall_pre_active", 32'(active), 32'd1);
    tick();
    check("stall_timeout", 32'(err_timeout), 32'd1);
    check("stall_active", 32'(active), 32'd0);
    sb.push_back(32'h1234_5678);
    sb.push_back(32'h9ABC_DEF0);
    drive(1'b1, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0); tick();
    drive(1'b0, '0, 1'b0, '0);
    tick(); tick();
    check("stall_resync_drain", 32'(sb.size()), 32'd0);

    // Overflow: six lane-1 pushes into a depth-4 FIFO
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, '0, 1'b1, 32'(i) * 32'h1111_1111);
      tick();
      if (i == 4) check("ovf_after_4", 32'(err_overflow), 32'd0);
      if (i == 5) check("ovf_after_5", 32'(err_overflow), 32'd1);
    end
    drive(1'b0, '0, 1'b0, '0); tick();
    check("ovf_wait_valid", 32'(valid_out), 32'd0);
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h1111_1111);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b0, '0);
    tick(); tick(); tick();
    check("ovf_stall_valid", 32'(valid_out), 32'd0);
    check("ovf_stall_active", 32'(active), 32'd1);
    check("ovf_drain", 32'(sb.size()), 32'd0);
    check("ovf_sticky", 32'(err_overflow), 32'd1);

    // Reset mid-stream with three lane-1 words buffered
    do_reset();
    sb.push_back(32'h0D0D_0D0D);
    sb.push_back(32'h0E0E_0E0E);
    drive(1'b1, 32'h0D0D_0D0D, 1'b1, 32'h0E0E_0E0E); tick();
    drive(1'b0, '0, 1'b1, 32'h2121_2121); tick();
    drive(1'b0, '0, 1'b1, 32'h2222_2222); tick();
    drive(1'b0, '0, 1'b1, 32'h2323_2323); tick();
    drive(1'b0, '0, 1'b0, '0);
    check("mid_pre_rst_data", data_out, 32'h0E0E_0E0E);
    check("mid_pre_rst_drain", 32'(sb.size()), 32'd0);
    do_reset();
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    sb.push_back(32'hAAAA_AAAA);
    sb.push_back(32'hBBBB_BBBB);
    drive(1'b1, 32'hAAAA_AAAA, 1'b1, 32'hBBBB_BBBB); tick();
    drive(1'b0, '0, 1'b0, '0);
    tick(); tick(); tick();
    check("mid_post_valid", 32'(valid_out), 32'd0);
    check("mid_post_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
